// File: rtl/motor_sensor_emulator.sv
// motor_sensor_emulator
//
// N-channel hall + quadrature-encoder emulator for motor-board bring-up and
// loopback self-test. Each channel steps a 6-state hall sequence and a 4-state
// quadrature sequence at programmable rates, with per-channel direction.
// Channel i starts i*STAGGER enabled cycles after the first enabled cycle
// following reset.
//
// Ports:
//   sysclk        in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   enable        in   run emulation; low freezes every channel
//   dir           in   per channel: 1 = forward, 0 = reverse
//   hall_period   in   cycles per hall state (shared); 0 = stall
//   enc_period    in   cycles per quadrature state (shared); 0 = stall
//   fault_inject  in   per channel: force hall outputs to 000 (MOTOR_EMU_FAULT_EN only)
//   hall_a/b/c    out  emulated hall sensors
//   enc_a/b       out  emulated quadrature encoder
//   hall_step     out  1-cycle strobe when a channel's hall state changes
//
// Build option: define MOTOR_EMU_FAULT_EN to add the fault_inject port and the
// registered hall forcing logic. Without it the hall outputs always show a
// valid sequence state.

module motor_sensor_emulator #(
    parameter int NUM_MOTORS   = 5,
    parameter int PERIOD_WIDTH = 16,
    parameter int STAGGER      = 100
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_MOTORS-1:0]   dir,
    input  logic [PERIOD_WIDTH-1:0] hall_period,
    input  logic [PERIOD_WIDTH-1:0] enc_period,
`ifdef MOTOR_EMU_FAULT_EN
    input  logic [NUM_MOTORS-1:0]   fault_inject,
`endif
    output logic [NUM_MOTORS-1:0]   hall_a,
    output logic [NUM_MOTORS-1:0]   hall_b,
    output logic [NUM_MOTORS-1:0]   hall_c,
    output logic [NUM_MOTORS-1:0]   enc_a,
    output logic [NUM_MOTORS-1:0]   enc_b,
    output logic [NUM_MOTORS-1:0]   hall_step
);

    localparam int START_MAX = (NUM_MOTORS - 1) * STAGGER;
    localparam int START_W   = (START_MAX > 0) ? $clog2(START_MAX + 1) : 1;

    // Hall sequence 101,100,110,010,011,001 (forward order).
    function automatic logic [2:0] hall_next(input logic [2:0] h, input logic fwd);
        logic [2:0] n;
        n = 3'b101;
        if (fwd) begin
            case (h)
                3'b101:  n = 3'b100;
                3'b100:  n = 3'b110;
                3'b110:  n = 3'b010;
                3'b010:  n = 3'b011;
                3'b011:  n = 3'b001;
                default: n = 3'b101;
            endcase
        end else begin
            case (h)
                3'b101:  n = 3'b001;
                3'b001:  n = 3'b011;
                3'b011:  n = 3'b010;
                3'b010:  n = 3'b110;
                3'b110:  n = 3'b100;
                default: n = 3'b101;
            endcase
        end
        return n;
    endfunction

    // Quadrature {a,b}: forward 00->10->11->01->00.
    function automatic logic [1:0] enc_next(input logic [1:0] e, input logic fwd);
        logic [1:0] n;
        n = 2'b00;
        if (fwd) begin
            case (e)
                2'b00:   n = 2'b10;
                2'b10:   n = 2'b11;
                2'b11:   n = 2'b01;
                default: n = 2'b00;
            endcase
        end else begin
            case (e)
                2'b00:   n = 2'b01;
                2'b01:   n = 2'b11;
                2'b11:   n = 2'b10;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

    // Counts enabled cycles since reset and saturates once the last channel
    // is active; only reset re-arms the stagger.
    logic [START_W-1:0] start_cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            start_cnt <= '0;
        end else if (enable && (start_cnt < START_W'(START_MAX))) begin
            start_cnt <= start_cnt + START_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
        logic                    active;
        logic                    hall_adv;
        logic                    enc_adv;
        logic                    step_q;
        logic [2:0]              hall_st;
        logic [2:0]              hall_nx;
        logic [2:0]              hall_out;
        logic [1:0]              enc_st;
        logic [PERIOD_WIDTH-1:0] hall_cnt;
        logic [PERIOD_WIDTH-1:0] enc_cnt;

        // start_cnt is 0 on the first enabled cycle, so channel 0 counts on
        // that very cycle and channel i exactly i*STAGGER cycles later.
        assign active = (start_cnt >= START_W'(g * STAGGER));

        // ">=" rather than "==" so a period lowered below the running count
        // steps on the next cycle instead of wrapping the counter.
        assign hall_adv = enable && active && (hall_period != '0) && (hall_cnt >= hall_period);
        assign enc_adv  = enable && active && (enc_period  != '0) && (enc_cnt  >= enc_period);
        assign hall_nx  = hall_adv ? hall_next(hall_st, dir[g]) : hall_st;

        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                hall_st  <= 3'b101;
                enc_st   <= 2'b00;
                hall_cnt <= '0;
                enc_cnt  <= '0;
                step_q   <= 1'b0;
            end else begin
                step_q <= hall_adv;
                if (enable && active) begin
                    hall_st <= hall_nx;
                    // A zero period parks the counter at 0 so a later
                    // non-zero period counts a full period from 1.
                    if (hall_period == '0) begin
                        hall_cnt <= '0;
                    end else if (hall_adv) begin
                        hall_cnt <= PERIOD_WIDTH'(1);
                    end else begin
                        hall_cnt <= hall_cnt + PERIOD_WIDTH'(1);
                    end

                    if (enc_adv) begin
                        enc_st <= enc_next(enc_st, dir[g]);
                    end
                    if (enc_period == '0) begin
                        enc_cnt <= '0;
                    end else if (enc_adv) begin
                        enc_cnt <= PERIOD_WIDTH'(1);
                    end else begin
                        enc_cnt <= enc_cnt + PERIOD_WIDTH'(1);
                    end
                end
            end
        end

`ifdef MOTOR_EMU_FAULT_EN
        // Forcing only masks the outputs; hall_st keeps sequencing underneath.
        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                hall_out <= 3'b101;
            end else if (fault_inject[g]) begin
                hall_out <= 3'b000;
            end else begin
                hall_out <= hall_nx;
            end
        end
`else
        assign hall_out = hall_st;
`endif

        assign hall_a[g]    = hall_out[2];
        assign hall_b[g]    = hall_out[1];
        assign hall_c[g]    = hall_out[0];
        assign enc_a[g]     = enc_st[1];
        assign enc_b[g]     = enc_st[0];
        assign hall_step[g] = step_q;
    end

endmodule

// File: tb/tb_motor_sensor_emulator.sv
module tb_motor_sensor_emulator;

    localparam int N = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  dir = '1;
    logic [15:0]   hall_period = '0;
    logic [15:0]   enc_period = '0;
`ifdef MOTOR_EMU_FAULT_EN
    logic [N-1:0]  fault_inject = '0;
`endif
    logic [N-1:0]  hall_a, hall_b, hall_c, enc_a, enc_b, hall_step;

    motor_sensor_emulator #(.NUM_MOTORS(N), .PERIOD_WIDTH(16), .STAGGER(100)) dut (
        .sysclk      (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .dir         (dir),
        .hall_period (hall_period),
        .enc_period  (enc_period),
`ifdef MOTOR_EMU_FAULT_EN
        .fault_inject(fault_inject),
`endif
        .hall_a      (hall_a),
        .hall_b      (hall_b),
        .hall_c      (hall_c),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .hall_step   (hall_step)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ch;
        longint     t;
        logic [2:0] v;
    } ev_t;

    ev_t        hq[$];
    ev_t        eq[$];
    int         n_chk = 0;
    int         n_bad = 0;
    logic [2:0] cur_h [N];
    logic [1:0] cur_e [N];
    bit         mon_on = 1'b0;
    logic [N-1:0] mask = '0;
    logic [2:0] hseq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    logic [1:0] eseq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    longint     t0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] hall_of(input int i);
        return {hall_a[i], hall_b[i], hall_c[i]};
    endfunction

    function automatic logic [1:0] enc_of(input int i);
        return {enc_a[i], enc_b[i]};
    endfunction

    task automatic push_h(input int ch, input longint t, input logic [2:0] v);
        ev_t e;
        e.ch = ch; e.t = t; e.v = v;
        hq.push_back(e);
    endtask

    task automatic push_e(input int ch, input longint t, input logic [1:0] v);
        ev_t e;
        e.ch = ch; e.t = t; e.v = {1'b0, v};
        eq.push_back(e);
    endtask

    // Monitor: pops the earliest expected event of a channel whenever that
    // channel strobes hall_step or its encoder outputs change.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = -1;
                if (hall_step[i]) begin
                    for (int k = 0; k < hq.size(); k++)
                        if (idx < 0 && hq[k].ch == i) idx = k;
                    if (idx < 0) begin
                        n_chk++; n_bad++;
                        $display("FAIL hall_step ch%0d: got strobe at cycle %0d expected none", i, cyc);
                    end else begin
                        check($sformatf("hall_step time ch%0d", i), cyc, hq[idx].t);
                        if (!mask[i]) check($sformatf("hall value ch%0d", i), hall_of(i), hq[idx].v);
                        cur_h[i] = hq[idx].v;
                        hq.delete(idx);
                    end
                end else if (!mask[i] && hall_of(i) !== cur_h[i]) begin
                    check($sformatf("hall hold ch%0d", i), hall_of(i), cur_h[i]);
                    cur_h[i] = hall_of(i);
                end

                idx = -1;
                if (enc_of(i) !== cur_e[i]) begin
                    for (int k = 0; k < eq.size(); k++)
                        if (idx < 0 && eq[k].ch == i) idx = k;
                    if (idx < 0) begin
                        n_chk++; n_bad++;
                        $display("FAIL enc change ch%0d: got %b at cycle %0d expected no change", i, enc_of(i), cyc);
                        cur_e[i] = enc_of(i);
                    end else begin
                        check($sformatf("enc time ch%0d", i), cyc, eq[idx].t);
                        check($sformatf("enc value ch%0d", i), enc_of(i), eq[idx].v[1:0]);
                        cur_e[i] = eq[idx].v[1:0];
                        eq.delete(idx);
                    end
                end
            end
        end
    end

    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " hall"}, {hall_a, hall_b, hall_c}, {5'h1F, 5'h00, 5'h1F});
        check({nm, " enc"}, {enc_a, enc_b}, 10'h000);
        check({nm, " hall_step"}, hall_step, 5'h00);
    endtask

    // Ends a phase by asserting reset mid-run; outputs must clear at once.
    task automatic end_phase(input longint tend, input string nm);
        wait_until(tend);
        #1;
        mon_on = 1'b0;
        rst_n  = 1'b0;
        enable = 1'b0;
        check({nm, " missed hall steps"}, hq.size(), 0);
        check({nm, " missed enc steps"}, eq.size(), 0);
        hq.delete();
        eq.delete();
        #1;
        check_reset_outputs({nm, " reset"});
    endtask

    task automatic start_run(input logic [N-1:0] d, input logic [15:0] hp, input logic [15:0] ep,
                             output longint ts);
        @(negedge clk);
        rst_n       = 1'b1;
        dir         = d;
        hall_period = hp;
        enc_period  = ep;
        for (int i = 0; i < N; i++) begin
            cur_h[i] = 3'b101;
            cur_e[i] = 2'b00;
        end
        mon_on = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        ts = cyc;          // cycle of the first enabled edge
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        longint t;
        int     k;
        repeat (3) @(negedge clk);
        check_reset_outputs("power-on");

        // Full hall sequence on every channel, staggered by 100.
        start_run(5'h1F, 16'd1000, 16'd0, t0);
        for (int i = 0; i < N; i++)
            for (int s = 1; s <= 6; s++)
                push_h(i, t0 + 1000 * s + 100 * i, hseq[s % 6]);
        end_phase(t0 + 6450, "hall seq");

        // Encoders; channel 0 reverse then flipped forward after 4 steps.
        start_run(5'b11110, 16'd0, 16'd40, t0);
        push_e(0, t0 + 40,  2'b01);
        push_e(0, t0 + 80,  2'b11);
        push_e(0, t0 + 120, 2'b10);
        push_e(0, t0 + 160, 2'b00);
        push_e(0, t0 + 200, 2'b10);
        push_e(0, t0 + 240, 2'b11);
        for (int i = 1; i < N; i++)
            for (int s = 1; 100 * i + 40 * s <= 250; s++)
                push_e(i, t0 + 100 * i + 40 * s, eseq[s % 4]);
        wait_until(t0 + 170);
        dir[0] = 1'b1;
        end_phase(t0 + 250, "enc dir");

        // Period changes: 1000 -> 0 -> 500 -> 1000 -> 200 at count 600.
        start_run(5'h1F, 16'd1000, 16'd0, t0);
        for (int i = 0; i < N; i++) begin
            push_h(i, t0 + 1000 + 100 * i, hseq[1]);
            push_h(i, t0 + 2501, hseq[2]);
            push_h(i, t0 + 3101, hseq[3]);
            push_h(i, t0 + 3301, hseq[4]);
            push_h(i, t0 + 3501, hseq[5]);
        end
        wait_until(t0 + 1500);
        hall_period = 16'd0;
        wait_until(t0 + 1800);
        check("period0 hall held", {hall_a, hall_b, hall_c}, {5'h1F, 5'h00, 5'h00});
        check("period0 no strobe", hall_step, 5'h00);
        wait_until(t0 + 2000);
        hall_period = 16'd500;
        wait_until(t0 + 2600);
        hall_period = 16'd1000;
        wait_until(t0 + 3100);
        hall_period = 16'd200;
        end_phase(t0 + 3550, "period change");

        // enable low for 300 cycles starting at 1500.
        start_run(5'h1F, 16'd1000, 16'd70, t0);
        for (int i = 0; i < N; i++) begin
            for (int s = 1; s <= 3; s++) begin
                t = 1000 * s + 100 * i;
                if (t > 1500) t = t + 300;
                if (t <= 2500) push_h(i, t0 + t, hseq[s % 6]);
            end
            for (int s = 1; s <= 40; s++) begin
                t = 70 * s + 100 * i;
                if (t > 1500) t = t + 300;
                if (t <= 2500) push_e(i, t0 + t, eseq[s % 4]);
            end
        end
        wait_until(t0 + 1500);
        enable = 1'b0;
        wait_until(t0 + 1650);
        check("freeze hall", {hall_a, hall_b, hall_c}, {5'h1F, 5'h00, 5'h00});
        check("freeze strobe", hall_step, 5'h00);
        for (int i = 0; i < N; i++) begin
            k = (1500 - 100 * i) / 70;
            check($sformatf("freeze enc ch%0d", i), enc_of(i), eseq[k % 4]);
        end
        wait_until(t0 + 1800);
        enable = 1'b1;
        end_phase(t0 + 2500, "enable freeze");

        // Coincident hall/encoder steps (and fault forcing when built in).
        start_run(5'h1F, 16'd40, 16'd30, t0);
        for (int i = 0; i < N; i++) begin
            for (int s = 1; 100 * i + 40 * s <= 400; s++)
                push_h(i, t0 + 100 * i + 40 * s, hseq[s % 6]);
            for (int s = 1; 100 * i + 30 * s <= 400; s++)
                push_e(i, t0 + 100 * i + 30 * s, eseq[s % 4]);
        end
`ifdef MOTOR_EMU_FAULT_EN
        wait_until(t0 + 300);
        mask[2] = 1'b1;
        fault_inject[2] = 1'b1;
        wait_until(t0 + 310);
        check("fault forced hall ch2", hall_of(2), 3'b000);
        check("fault other hall ch1", hall_of(1), hseq[5]);
        wait_until(t0 + 349);
        check("fault still forced ch2", hall_of(2), 3'b000);
        wait_until(t0 + 350);
        fault_inject[2] = 1'b0;
        wait_until(t0 + 351);
        check("fault release hall ch2", hall_of(2), hseq[3]);
        wait_until(t0 + 352);
        mask[2] = 1'b0;
`endif
        end_phase(t0 + 400, "coincident");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
